reg_xfer_sequencer: RTL and testbench

//   Control stage directly upstream of the register_gp bank.

---
 rtl/reg_xfer_sequencer_pkg.sv | 24 ++
 rtl/reg_xfer_sequencer_if.sv | 40 ++++
 rtl/reg_xfer_sequencer_onehot_decode.sv | 16 +
 rtl/reg_xfer_sequencer.sv | 139 +++++++++++++
 tb/tb_reg_xfer_sequencer.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_xfer_sequencer_pkg.sv
// Shared encodings for the register-transfer sequencer: opcodes, FSM states, strobe invariant helper.
// Latency: n/a (types only); backpressure: n/a.
package reg_xfer_sequencer_pkg;

    typedef enum logic [1:0] {
        OP_NOP = 2'b00,
        OP_MOV = 2'b01,
        OP_ALU = 2'b10,
        OP_LDI = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_XFER     = 2'b01,
        ST_ALU_EVAL = 2'b10,
        ST_ALU_WB   = 2'b11
    } state_e;

    // True when no more than one bit of v is set (bus-source and load exclusivity).
    function automatic logic at_most_one(input logic [31:0] v);
        return (v & (v - 32'd1)) == 32'd0;
    endfunction

endpackage

// File: rtl/reg_xfer_sequencer_if.sv
// Command handshake plus register-bank strobe bundle between issuer, sequencer and register_gp bank.
// Latency: wires only; backpressure: cmd_valid/cmd_ready, hold freezes the sequencer.
interface reg_xfer_sequencer_if #(
    parameter int WIDTH    = 8,
    parameter int NUM_REGS = 4
);
    localparam int IDX_W = $clog2(NUM_REGS);

    logic                cmd_valid;
    logic                cmd_ready;
    logic [1:0]          cmd_op;
    logic [IDX_W-1:0]    cmd_dst;
    logic [IDX_W-1:0]    cmd_src_a;
    logic [IDX_W-1:0]    cmd_src_b;
    logic [WIDTH-1:0]    cmd_imm;
    logic                hold;
    logic [NUM_REGS-1:0] assert_bus;
    logic [NUM_REGS-1:0] assert_lhs;
    logic [NUM_REGS-1:0] assert_rhs;
    logic [NUM_REGS-1:0] load_bus;
    logic                alu_latch;
    logic                alu_assert;
    logic [WIDTH-1:0]    imm_out;
    logic                imm_en;
    logic                cmd_done;
    logic                cmd_err;

    modport master (
        output cmd_valid, cmd_op, cmd_dst, cmd_src_a, cmd_src_b, cmd_imm, hold,
        input  cmd_ready, assert_bus, assert_lhs, assert_rhs, load_bus,
               alu_latch, alu_assert, imm_out, imm_en, cmd_done, cmd_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_dst, cmd_src_a, cmd_src_b, cmd_imm, hold,
        output cmd_ready, assert_bus, assert_lhs, assert_rhs, load_bus,
               alu_latch, alu_assert, imm_out, imm_en, cmd_done, cmd_err
    );

endinterface

// File: rtl/reg_xfer_sequencer_onehot_decode.sv
// Register index to one-hot strobe vector, gated by an enable.
// Latency: combinational; backpressure: none.
module reg_xfer_sequencer_onehot_decode #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [IDX_W-1:0] idx,
    input  logic             en,
    output logic [N-1:0]     onehot
);

    for (genvar i = 0; i < N; i++) begin : g_bit
        assign onehot[i] = en && (idx == IDX_W'(i));
    end

endmodule

// File: rtl/reg_xfer_sequencer.sv
// Steps one register-transfer command through timed states and drives register_gp bank strobes.
// Latency: MOV/LDI/NOP load 1 edge after accept, ALU 2 edges; backpressure: cmd_ready only in IDLE, hold freezes.
module reg_xfer_sequencer
    import reg_xfer_sequencer_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int NUM_REGS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    reg_xfer_sequencer_if.slave   bus
);

    localparam int IDX_W = $clog2(NUM_REGS);
    localparam logic [IDX_W:0] REG_LIMIT = (IDX_W + 1)'(NUM_REGS);

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [IDX_W-1:0] dst_q, dst_d;
    logic [IDX_W-1:0] src_a_q, src_a_d;
    logic [IDX_W-1:0] src_b_q, src_b_d;
    logic [WIDTH-1:0] imm_q, imm_d;
    logic             err_q, err_d;

    op_e  cmd_op;
    logic cmd_ready_s;
    logic accept;
    logic idx_bad;

    function automatic logic idx_oob(input logic [IDX_W-1:0] idx);
        return {1'b0, idx} >= REG_LIMIT;
    endfunction

    assign cmd_op      = op_e'(bus.cmd_op);
    assign cmd_ready_s = (state_q == ST_IDLE) && !bus.hold;
    assign accept      = bus.cmd_valid && cmd_ready_s;

    // Only the indices an opcode actually uses can make it illegal.
    always_comb begin
        idx_bad = 1'b0;
        case (cmd_op)
            OP_MOV:  idx_bad = idx_oob(bus.cmd_src_a) || idx_oob(bus.cmd_dst);
            OP_ALU:  idx_bad = idx_oob(bus.cmd_src_a) || idx_oob(bus.cmd_src_b) || idx_oob(bus.cmd_dst);
            OP_LDI:  idx_bad = idx_oob(bus.cmd_dst);
            default: idx_bad = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        dst_d   = dst_q;
        src_a_d = src_a_q;
        src_b_d = src_b_q;
        imm_d   = imm_q;
        err_d   = 1'b0;
        if (accept) begin
            op_d    = cmd_op;
            dst_d   = bus.cmd_dst;
            src_a_d = bus.cmd_src_a;
            src_b_d = bus.cmd_src_b;
            imm_d   = bus.cmd_imm;
            if (idx_bad) begin
                err_d = 1'b1;
            end else if (cmd_op == OP_ALU) begin
                state_d = ST_ALU_EVAL;
            end else begin
                state_d = ST_XFER;
            end
        end else if (!bus.hold) begin
            case (state_q)
                ST_XFER:     state_d = ST_IDLE;
                ST_ALU_EVAL: state_d = ST_ALU_WB;
                ST_ALU_WB:   state_d = ST_IDLE;
                default:     state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= OP_NOP;
            dst_q   <= '0;
            src_a_q <= '0;
            src_b_q <= '0;
            imm_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            dst_q   <= dst_d;
            src_a_q <= src_a_d;
            src_b_q <= src_b_d;
            imm_q   <= imm_d;
            err_q   <= err_d;
        end
    end

    // Strobes come only from registered state; hold gates every one of them.
    logic in_xfer, in_eval, in_wb;
    logic en_bus, en_load, imm_en_s;

    assign in_xfer  = !bus.hold && (state_q == ST_XFER);
    assign in_eval  = !bus.hold && (state_q == ST_ALU_EVAL);
    assign in_wb    = !bus.hold && (state_q == ST_ALU_WB);
    assign en_bus   = in_xfer && (op_q == OP_MOV);
    assign en_load  = (in_xfer && (op_q != OP_NOP)) || in_wb;
    assign imm_en_s = in_xfer && (op_q == OP_LDI);

    reg_xfer_sequencer_onehot_decode #(.N(NUM_REGS)) u_dec_bus (
        .idx(src_a_q), .en(en_bus), .onehot(bus.assert_bus)
    );
    reg_xfer_sequencer_onehot_decode #(.N(NUM_REGS)) u_dec_lhs (
        .idx(src_a_q), .en(in_eval), .onehot(bus.assert_lhs)
    );
    reg_xfer_sequencer_onehot_decode #(.N(NUM_REGS)) u_dec_rhs (
        .idx(src_b_q), .en(in_eval), .onehot(bus.assert_rhs)
    );
    reg_xfer_sequencer_onehot_decode #(.N(NUM_REGS)) u_dec_load (
        .idx(dst_q), .en(en_load), .onehot(bus.load_bus)
    );

    assign bus.cmd_ready  = cmd_ready_s;
    assign bus.alu_latch  = in_eval;
    assign bus.alu_assert = in_wb;
    assign bus.imm_en     = imm_en_s;
    assign bus.imm_out    = imm_en_s ? imm_q : '0;
    assign bus.cmd_done   = in_xfer || in_wb;
    assign bus.cmd_err    = err_q;

    always @(posedge clk) begin
        if (rst_n) begin
            assert (at_most_one(32'({bus.assert_bus, bus.alu_assert, bus.imm_en})));
            assert (at_most_one(32'(bus.load_bus)));
        end
    end

endmodule

// File: tb/tb_reg_xfer_sequencer.sv
// Directed scoreboard bench: stimulus pushes expected strobe vectors, a negedge monitor pops on any activity.
// Covers 4-register and 3-register instances (the latter for out-of-range index rejection).
module tb_reg_xfer_sequencer;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    reg_xfer_sequencer_if #(.WIDTH(8), .NUM_REGS(4)) if4 ();
    reg_xfer_sequencer_if #(.WIDTH(8), .NUM_REGS(3)) if3 ();

    reg_xfer_sequencer #(.WIDTH(8), .NUM_REGS(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
    reg_xfer_sequencer #(.WIDTH(8), .NUM_REGS(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

    typedef struct packed {
        logic [3:0] bus;
        logic [3:0] lhs;
        logic [3:0] rhs;
        logic [3:0] load;
        logic       latch;
        logic       aasrt;
        logic       imm_en;
        logic [7:0] imm;
        logic       done;
        logic       err;
    } exp_t;

    exp_t q4[$];
    exp_t q3[$];
    int checks = 0;
    int errors = 0;

    localparam logic [1:0] NOP = 2'b00, MOV = 2'b01, ALU = 2'b10, LDI = 2'b11;

    function automatic exp_t mk(input logic [3:0] b, input logic [3:0] l, input logic [3:0] r,
                                input logic [3:0] ld, input logic la, input logic aa, input logic ie,
                                input logic [7:0] im, input logic dn, input logic er);
        exp_t e;
        e = {b, l, r, ld, la, aa, ie, im, dn, er};
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic score(input int which, input exp_t act);
        exp_t e;
        if (which == 4) begin
            if (q4.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_out dut4: got %h expected no activity", act);
                return;
            end
            e = q4.pop_front();
        end else begin
            if (q3.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_out dut3: got %h expected no activity", act);
                return;
            end
            e = q3.pop_front();
        end
        if (!e.imm_en) act.imm = 8'h00;
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL out_dut%0d: got %h expected %h", which, act, e);
        end
    endtask

    always @(negedge clk) begin
        exp_t a4;
        exp_t a3;
        a4 = {if4.assert_bus, if4.assert_lhs, if4.assert_rhs, if4.load_bus, if4.alu_latch,
              if4.alu_assert, if4.imm_en, if4.imm_out, if4.cmd_done, if4.cmd_err};
        a3 = {1'b0, if3.assert_bus, 1'b0, if3.assert_lhs, 1'b0, if3.assert_rhs, 1'b0, if3.load_bus,
              if3.alu_latch, if3.alu_assert, if3.imm_en, if3.imm_out, if3.cmd_done, if3.cmd_err};
        if (|{a4.bus, a4.lhs, a4.rhs, a4.load, a4.latch, a4.aasrt, a4.imm_en, a4.done, a4.err})
            score(4, a4);
        if (|{a3.bus, a3.lhs, a3.rhs, a3.load, a3.latch, a3.aasrt, a3.imm_en, a3.done, a3.err})
            score(3, a3);
    end

    task automatic issue4(input logic [1:0] op, input logic [1:0] dst, input logic [1:0] a,
                          input logic [1:0] b, input logic [7:0] imm);
        int n = 0;
        while (!if4.cmd_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("ready_wait4", 32'(if4.cmd_ready), 32'd1);
        if4.cmd_op = op; if4.cmd_dst = dst; if4.cmd_src_a = a; if4.cmd_src_b = b; if4.cmd_imm = imm;
        if4.cmd_valid = 1'b1;
        @(posedge clk); #1;
        if4.cmd_valid = 1'b0;
    endtask

    task automatic issue3(input logic [1:0] op, input logic [1:0] dst, input logic [1:0] a,
                          input logic [1:0] b, input logic [7:0] imm);
        int n = 0;
        while (!if3.cmd_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("ready_wait3", 32'(if3.cmd_ready), 32'd1);
        if3.cmd_op = op; if3.cmd_dst = dst; if3.cmd_src_a = a; if3.cmd_src_b = b; if3.cmd_imm = imm;
        if3.cmd_valid = 1'b1;
        @(posedge clk); #1;
        if3.cmd_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        if4.cmd_valid = 1'b0; if4.hold = 1'b0; if4.cmd_op = NOP; if4.cmd_dst = '0;
        if4.cmd_src_a = '0; if4.cmd_src_b = '0; if4.cmd_imm = '0;
        if3.cmd_valid = 1'b0; if3.hold = 1'b0; if3.cmd_op = NOP; if3.cmd_dst = '0;
        if3.cmd_src_a = '0; if3.cmd_src_b = '0; if3.cmd_imm = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_strobes", 32'({if4.assert_bus, if4.assert_lhs, if4.assert_rhs, if4.load_bus,
            if4.alu_latch, if4.alu_assert, if4.imm_en, if4.cmd_done, if4.cmd_err}), 32'd0);
        chk("rst_ready", 32'(if4.cmd_ready), 32'd1);
        chk("rst_imm_out", 32'(if4.imm_out), 32'd0);
        chk("rst_ready3", 32'(if3.cmd_ready), 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // MOV dst=2 src=1
        q4.push_back(mk(4'b0010, 4'b0, 4'b0, 4'b0100, 0, 0, 0, 8'h00, 1, 0));
        issue4(MOV, 2'd2, 2'd1, 2'd0, 8'h00);
        chk("mov_busy", 32'(if4.cmd_ready), 32'd0);
        @(posedge clk); #1;
        chk("mov_ready_after", 32'(if4.cmd_ready), 32'd1);

        // ALU dst=3 a=0 b=1
        q4.push_back(mk(4'b0, 4'b0001, 4'b0010, 4'b0, 1, 0, 0, 8'h00, 0, 0));
        q4.push_back(mk(4'b0, 4'b0, 4'b0, 4'b1000, 0, 1, 0, 8'h00, 1, 0));
        issue4(ALU, 2'd3, 2'd0, 2'd1, 8'h00);
        @(posedge clk); #1;
        chk("alu_wb_busy", 32'(if4.cmd_ready), 32'd0);
        @(posedge clk); #1;
        chk("alu_ready_after", 32'(if4.cmd_ready), 32'd1);

        // LDI dst=0 imm=A5, then NOP, MOV same reg, ALU same operands
        q4.push_back(mk(4'b0, 4'b0, 4'b0, 4'b0001, 0, 0, 1, 8'hA5, 1, 0));
        issue4(LDI, 2'd0, 2'd0, 2'd0, 8'hA5);
        q4.push_back(mk(4'b0, 4'b0, 4'b0, 4'b0, 0, 0, 0, 8'h00, 1, 0));
        issue4(NOP, 2'd1, 2'd2, 2'd3, 8'h3C);
        q4.push_back(mk(4'b1000, 4'b0, 4'b0, 4'b1000, 0, 0, 0, 8'h00, 1, 0));
        issue4(MOV, 2'd3, 2'd3, 2'd0, 8'h00);
        q4.push_back(mk(4'b0, 4'b0100, 4'b0100, 4'b0, 1, 0, 0, 8'h00, 0, 0));
        q4.push_back(mk(4'b0, 4'b0, 4'b0, 4'b0010, 0, 1, 0, 8'h00, 1, 0));
        issue4(ALU, 2'd1, 2'd2, 2'd2, 8'h00);

        // hold for 3 cycles between ALU_EVAL and ALU_WB
        q4.push_back(mk(4'b0, 4'b1000, 4'b0010, 4'b0, 1, 0, 0, 8'h00, 0, 0));
        q4.push_back(mk(4'b0, 4'b0, 4'b0, 4'b0001, 0, 1, 0, 8'h00, 1, 0));
        issue4(ALU, 2'd0, 2'd3, 2'd1, 8'h00);
        @(posedge clk); #1;
        if4.hold = 1'b1;
        #1;
        chk("hold_strobes", 32'({if4.load_bus, if4.alu_assert, if4.cmd_done}), 32'd0);
        chk("hold_busy", 32'(if4.cmd_ready), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        if4.hold = 1'b0;
        @(posedge clk); #1;
        chk("hold_ready_after", 32'(if4.cmd_ready), 32'd1);

        // hold in IDLE blocks acceptance
        if4.hold = 1'b1;
        if4.cmd_op = LDI; if4.cmd_dst = 2'd2; if4.cmd_imm = 8'h5A; if4.cmd_valid = 1'b1;
        q4.push_back(mk(4'b0, 4'b0, 4'b0, 4'b0100, 0, 0, 1, 8'h5A, 1, 0));
        #1;
        chk("idle_hold_ready", 32'(if4.cmd_ready), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        if4.hold = 1'b0;
        #1;
        chk("idle_release_ready", 32'(if4.cmd_ready), 32'd1);
        @(posedge clk); #1;
        if4.cmd_valid = 1'b0;
        chk("idle_release_busy", 32'(if4.cmd_ready), 32'd0);

        // cmd_valid while busy is ignored
        q4.push_back(mk(4'b0, 4'b0001, 4'b0010, 4'b0, 1, 0, 0, 8'h00, 0, 0));
        q4.push_back(mk(4'b0, 4'b0, 4'b0, 4'b0100, 0, 1, 0, 8'h00, 1, 0));
        issue4(ALU, 2'd2, 2'd0, 2'd1, 8'h00);
        if4.cmd_op = MOV; if4.cmd_dst = 2'd1; if4.cmd_src_a = 2'd3; if4.cmd_valid = 1'b1;
        @(posedge clk); #1;
        if4.cmd_valid = 1'b0;
        @(posedge clk); #1;

        // reset during ALU_EVAL abandons the command
        issue4(ALU, 2'd3, 2'd1, 2'd2, 8'h00);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_clear", 32'({if4.assert_lhs, if4.assert_rhs, if4.alu_latch, if4.load_bus}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mid_idle", 32'(if4.cmd_ready), 32'd1);

        q4.push_back(mk(4'b0100, 4'b0, 4'b0, 4'b0001, 0, 0, 0, 8'h00, 1, 0));
        issue4(MOV, 2'd0, 2'd2, 2'd0, 8'h00);
        @(posedge clk); #1;

        // NUM_REGS=3: out-of-range indices rejected
        q3.push_back(mk(4'b0, 4'b0, 4'b0, 4'b0, 0, 0, 0, 8'h00, 0, 1));
        issue3(MOV, 2'd3, 2'd0, 2'd0, 8'h00);
        chk("err_stays_idle", 32'(if3.cmd_ready), 32'd1);
        q3.push_back(mk(4'b0, 4'b0, 4'b0, 4'b0, 0, 0, 0, 8'h00, 0, 1));
        issue3(ALU, 2'd0, 2'd1, 2'd3, 8'h00);
        q3.push_back(mk(4'b0010, 4'b0, 4'b0, 4'b0100, 0, 0, 0, 8'h00, 1, 0));
        issue3(MOV, 2'd2, 2'd1, 2'd0, 8'h00);
        q3.push_back(mk(4'b0, 4'b0, 4'b0, 4'b0, 0, 0, 0, 8'h00, 0, 1));
        issue3(LDI, 2'd3, 2'd0, 2'd0, 8'hFF);

        repeat (5) @(posedge clk);
        #1;
        chk("q4_drained", 32'(q4.size()), 32'd0);
        chk("q3_drained", 32'(q3.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
